// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RV64 memory-access stage: memory-op encoding,
// stage FSM states, and access-size / byte-enable helpers.
package riscv_pkg;

  localparam int ADDR_W = 48;
  localparam int XLEN   = 64;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LD       = 4'd4,
    LBU      = 4'd5,
    LHU      = 4'd6,
    LWU      = 4'd7,
    SB       = 4'd8,
    SH       = 4'd9,
    SW       = 4'd10,
    SD       = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW) || (op == SD);
  endfunction

  // log2 of the access size in bytes (0 = byte ... 3 = double)
  function automatic logic [1:0] size_log2(input mem_op_e op);
    case (op)
      LB, LBU, SB: return 2'd0;
      LH, LHU, SH: return 2'd1;
      LW, LWU, SW: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [2:0] offset);
    if (op == MEM_NONE) return 1'b0;
    case (size_log2(op))
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      2'd2:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

  function automatic logic [7:0] byte_en(input mem_op_e op, input logic [2:0] offset);
    case (size_log2(op))
      2'd0:    return 8'h01 << offset;
      2'd1:    return 8'h03 << offset;
      2'd2:    return 8'h0F << offset;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the addressed lane out of an 8-byte memory word
// and sign/zero-extends it; FP word loads are NaN-boxed.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  mem_op_e         mem_op,
  input  logic            reg_type,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (mem_op)
      LB:  data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:  data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LW:  data = reg_type ? {{(XLEN-32){1'b1}}, shifted[31:0]}
                           : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LBU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU: data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LWU: data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/stage4_mem.sv
// Memory-access stage: passes ALU results through in one cycle and performs
// loads/stores over a single-outstanding req/gnt/rvalid data-memory port.
module stage4_mem
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              valid_ex,
  input  logic [XLEN-1:0]   op_ex,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [4:0]        rd_ex,
  input  logic              we_rd_ex,
  input  logic              reg_type_ex,
  input  mem_op_e           mem_op_ex,
  output logic              stall_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              valid_mem,
  output logic [XLEN-1:0]   op_mem,
  output logic [4:0]        rd_mem,
  output logic              we_rd_mem,
  output logic              reg_type_mem,
  output logic              misalign_mem
);

  mem_state_e        state;
  logic [XLEN-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  logic              we_q;
  logic              type_q;
  mem_op_e           memop_q;
  logic [XLEN-1:0]   load_data;

  // Request fields come straight from the captured instruction, so they stay
  // stable for the whole REQ phase without extra registers.
  assign stall_mem  = (state != IDLE);
  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req && is_store(memop_q);
  assign dmem_addr  = dmem_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign dmem_be    = dmem_req ? byte_en(memop_q, addr_q[2:0]) : '0;
  assign dmem_wdata = dmem_req ? (op_q << {addr_q[2:0], 3'b000}) : '0;

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .offset   (addr_q[2:0]),
    .mem_op   (memop_q),
    .reg_type (type_q),
    .data     (load_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      type_q       <= 1'b0;
      memop_q      <= MEM_NONE;
      valid_mem    <= 1'b0;
      op_mem       <= '0;
      rd_mem       <= '0;
      we_rd_mem    <= 1'b0;
      reg_type_mem <= 1'b0;
      misalign_mem <= 1'b0;
    end else begin
      valid_mem    <= 1'b0;
      we_rd_mem    <= 1'b0;
      misalign_mem <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_ex) begin
            op_q    <= op_ex;
            addr_q  <= mem_addr;
            rd_q    <= rd_ex;
            we_q    <= we_rd_ex;
            type_q  <= reg_type_ex;
            memop_q <= mem_op_ex;
            if (mem_op_ex == MEM_NONE) begin
              valid_mem    <= 1'b1;
              op_mem       <= op_ex;
              rd_mem       <= rd_ex;
              we_rd_mem    <= we_rd_ex;
              reg_type_mem <= reg_type_ex;
            end else if (is_misaligned(mem_op_ex, mem_addr[2:0])) begin
              // Trap instead of accessing memory; the write-back is suppressed.
              valid_mem    <= 1'b1;
              misalign_mem <= 1'b1;
              rd_mem       <= rd_ex;
              reg_type_mem <= reg_type_ex;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            if (is_store(memop_q)) begin
              state        <= IDLE;
              valid_mem    <= 1'b1;
              rd_mem       <= rd_q;
              reg_type_mem <= type_q;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state        <= IDLE;
            valid_mem    <= 1'b1;
            op_mem       <= load_data;
            rd_mem       <= rd_q;
            we_rd_mem    <= we_q;
            reg_type_mem <= type_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage4_mem.sv
// Randomized scoreboard bench for stage4_mem: a byte-level reference memory
// predicts results and request fields; a memory responder and monitor compare.
module tb_stage4_mem;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        valid_ex = 1'b0;
  logic [63:0] op_ex = '0;
  logic [47:0] mem_addr = '0;
  logic [4:0]  rd_ex = '0;
  logic        we_rd_ex = 1'b0;
  logic        reg_type_ex = 1'b0;
  mem_op_e     mem_op_ex = MEM_NONE;
  logic        stall_mem, dmem_req, dmem_we;
  logic [47:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [63:0] dmem_rdata = '0;
  logic        valid_mem, we_rd_mem, reg_type_mem, misalign_mem;
  logic [63:0] op_mem;
  logic [4:0]  rd_mem;

  always #5 clk = ~clk;

  stage4_mem dut (
    .clk(clk), .n_reset(n_reset), .valid_ex(valid_ex), .op_ex(op_ex),
    .mem_addr(mem_addr), .rd_ex(rd_ex), .we_rd_ex(we_rd_ex),
    .reg_type_ex(reg_type_ex), .mem_op_ex(mem_op_ex), .stall_mem(stall_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .valid_mem(valid_mem),
    .op_mem(op_mem), .rd_mem(rd_mem), .we_rd_mem(we_rd_mem),
    .reg_type_mem(reg_type_mem), .misalign_mem(misalign_mem)
  );

  typedef struct {
    logic [63:0] op;
    logic [4:0]  rd;
    logic        we, rt, mis, chk_op, chk_lat;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [47:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
  } req_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  logic [7:0]  ref_mem [256];
  logic [63:0] env_mem [32];
  int          total = 0, bad = 0, cyc = 0, valid_cnt = 0;
  int          gnt_dly = -1, rv_dly = -1, last_req_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic int nbytes(input mem_op_e op);
    if (op inside {LB, LBU, SB}) return 1;
    if (op inside {LH, LHU, SH}) return 2;
    if (op inside {LW, LWU, SW}) return 4;
    return 8;
  endfunction

  // Reference load: gather bytes from the byte memory, then extend by value arithmetic.
  function automatic logic [63:0] ref_load(input mem_op_e op, input logic [47:0] a, input logic rt);
    int n = nbytes(op);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[(a[7:0] + i) & 255]) << (8 * i));
    if ((op inside {LB, LH, LW}) && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    if (op == LW && rt) v[63:32] = 32'hFFFF_FFFF;
    return v;
  endfunction

  task automatic set_word(input int idx, input logic [63:0] w);
    env_mem[idx] = w;
    for (int i = 0; i < 8; i++) ref_mem[idx * 8 + i] = w[8*i +: 8];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_ex = 1'b0;
    end
  endtask

  task automatic issue(input mem_op_e op, input logic [47:0] a, input logic [63:0] d,
                       input logic [4:0] rd, input logic we, input logic rt);
    int   waitc = 0;
    int   n = nbytes(op);
    logic mis;
    exp_t e;
    req_t r;
    @(negedge clk);
    valid_ex = 1'b1; mem_op_ex = op; mem_addr = a; op_ex = d;
    rd_ex = rd; we_rd_ex = we; reg_type_ex = rt;
    while (stall_mem) begin
      waitc++;
      if (waitc > 300) begin
        check("accept_timeout", stall_mem, 1'b0);
        finish_test();
      end
      @(negedge clk);
    end
    mis = (op != MEM_NONE) && ((int'(a[2:0]) % n) != 0);
    e.op = '0; e.rd = rd; e.rt = rt; e.mis = mis; e.we = we;
    e.chk_op = 1'b0; e.chk_lat = 1'b0; e.cyc = cyc + 1;
    if (op == MEM_NONE) begin
      e.op = d; e.chk_op = 1'b1; e.chk_lat = 1'b1;
    end else if (mis) begin
      e.we = 1'b0; e.chk_lat = 1'b1;
    end else begin
      r.addr  = {a[47:3], 3'b000};
      r.we    = is_store(op);
      r.be    = 8'((16'(1) << n) - 16'(1)) << a[2:0];
      r.wdata = d << (8 * a[2:0]);
      req_q.push_back(r);
      if (is_store(op)) begin
        e.we = 1'b0;
        for (int i = 0; i < n; i++) ref_mem[(a[7:0] + i) & 255] = d[8*i +: 8];
      end else begin
        e.op = ref_load(op, a, rt); e.chk_op = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: pops one expectation per valid_mem pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_reset) begin
        if (valid_mem) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            check("spurious_valid", valid_mem, 1'b0);
          end else begin
            e = exp_q.pop_front();
            if (e.chk_op) check("op_mem", op_mem, e.op);
            check("rd_mem", 64'(rd_mem), 64'(e.rd));
            check("we_rd_mem", we_rd_mem, e.we);
            check("reg_type_mem", reg_type_mem, e.rt);
            check("misalign_mem", misalign_mem, e.mis);
            if (e.chk_lat) check("latency", 64'(cyc), 64'(e.cyc));
          end
        end else begin
          check("we_idle", we_rd_mem, 1'b0);
        end
      end
    end
  end

  // Data-memory responder with programmable grant / read-data delays.
  initial begin
    req_t        r;
    int          d, cycles;
    logic [7:0]  be_s;
    logic [63:0] wd_s;
    logic [4:0]  idx;
    forever begin
      @(negedge clk);
      if (n_reset && dmem_req) begin
        if (req_q.size() == 0) begin
          check("spurious_req", dmem_req, 1'b0);
          r.addr = dmem_addr; r.we = dmem_we; r.be = dmem_be; r.wdata = dmem_wdata;
        end else begin
          r = req_q.pop_front();
        end
        d = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
        cycles = 1;
        repeat (d) begin
          @(negedge clk);
          cycles++;
          check("req_held", dmem_req, 1'b1);
        end
        check("dmem_addr", 64'(dmem_addr), 64'(r.addr));
        check("dmem_we", dmem_we, r.we);
        if (r.we) begin
          check("dmem_be", 64'(dmem_be), 64'(r.be));
          check("dmem_wdata", dmem_wdata, r.wdata);
        end
        be_s = dmem_be; wd_s = dmem_wdata; idx = dmem_addr[7:3];
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        last_req_cycles = cycles;
        if (r.we) begin
          for (int b = 0; b < 8; b++) if (be_s[b]) env_mem[idx][8*b +: 8] = wd_s[8*b +: 8];
        end else begin
          d = (rv_dly < 0) ? int'($urandom_range(0, 2)) : rv_dly;
          repeat (d) @(negedge clk);
          dmem_rdata  = env_mem[idx];
          dmem_rvalid = 1'b1;
          @(negedge clk);
          dmem_rvalid = 1'b0;
          dmem_rdata  = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    bad++;
    total++;
    finish_test();
  end

  initial begin
    mem_op_e     op;
    logic [7:0]  a8;
    int          vc0;
    for (int i = 0; i < 32; i++) set_word(i, {$urandom, $urandom});

    // Reset state
    #12;
    check("rst_valid_mem", valid_mem, 1'b0);
    check("rst_outputs", {op_mem, 3'b000, rd_mem, we_rd_mem, reg_type_mem, misalign_mem}, '0);
    check("rst_dmem", {dmem_req, dmem_we, dmem_be, stall_mem}, '0);
    check("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    @(negedge clk);
    n_reset = 1'b1;

    // Pass-through ALU result
    issue(MEM_NONE, 48'h0, 64'h1234, 5'd5, 1'b1, 1'b0);
    idle(1);
    check("none_no_stall", stall_mem, 1'b0);
    wait_drain();

    // Byte store into lane 3, grant after two wait cycles
    gnt_dly = 2;
    issue(SB, 48'h1003, 64'hAB, 5'd9, 1'b1, 1'b0);
    idle(1);
    wait_drain();
    check("sb_req_cycles", 64'(last_req_cycles), 64'd3);
    gnt_dly = -1;

    // Signed and unsigned byte loads of 0x80
    set_word(0, 64'h0080_0000_0000_0000);
    issue(LB, 48'h2006, 64'h0, 5'd7, 1'b1, 1'b0);
    issue(LBU, 48'h2006, 64'h0, 5'd8, 1'b1, 1'b0);
    idle(1);
    wait_drain();

    // NaN-boxed FP word load
    set_word(2, 64'h1234_5678_3F80_0000);
    issue(LW, 48'h10, 64'h0, 5'd3, 1'b1, 1'b1);
    idle(1);
    wait_drain();

    // Misaligned double: no request, exception flag, write suppressed
    issue(LD, 48'h44, 64'h0, 5'd4, 1'b1, 1'b0);
    idle(1);
    check("mis_no_req", dmem_req, 1'b0);
    wait_drain();

    // Reset while waiting for load data; the late rvalid must be ignored
    gnt_dly = 0; rv_dly = 6;
    issue(LD, 48'h40, 64'h0, 5'd6, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    check("in_wait_stall", stall_mem, 1'b1);
    #2 n_reset = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_req", dmem_req, 1'b0);
    check("rst_mid_stall", stall_mem, 1'b0);
    check("rst_mid_outputs", {op_mem, 3'b000, rd_mem, valid_mem, we_rd_mem, misalign_mem}, '0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    vc0 = valid_cnt;
    idle(12);
    check("late_rvalid_ignored", 64'(valid_cnt - vc0), 64'd0);
    gnt_dly = -1; rv_dly = -1;

    // Random mix of ALU, load and store traffic
    for (int n = 0; n < 300; n++) begin
      op = mem_op_e'($urandom_range(0, 11));
      a8 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a8 = a8 & ~8'(nbytes(op) - 1);
      issue(op, {$urandom, 8'($urandom), a8}, {$urandom, $urandom},
            5'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) < 3) idle(1);
    end
    idle(1);
    wait_drain();
    idle(4);
    finish_test();
  end

endmodule

// File: doc/stage4_mem.md
Name: stage4_mem

Overview:
- Memory-access stage of the RV64IMFD pipeline, directly downstream of the execute stage (stage3).
- Consumes the execute result, effective address, destination register and register-file type.
- Performs loads and stores through a single-outstanding request/grant/rvalid data-memory port.
- Produces op_mem/rd_mem, which feed the execute forwarding path and the writeback stage.

Parameters:
- ADDR_W, 48, data-memory byte-address width (matches mem_addr from execute).
- XLEN, 64, data width.

Ports:
- clk  input  1  clock
- n_reset  input  1  asynchronous active-low reset
- valid_ex  input  1  execute stage presents a valid instruction
- op_ex  input  64  ALU result (non-mem) or store data (store)
- mem_addr  input  48  effective address
- rd_ex  input  5  destination register
- we_rd_ex  input  1  register write enable
- reg_type_ex  input  1  0 = integer file, 1 = FP file
- mem_op_ex  input  4  mem_op_e from package
- stall_mem  output  1  holds execute and earlier stages
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = store
- dmem_addr  output  48  8-byte-aligned address (low 3 bits zero)
- dmem_be  output  8  byte enables
- dmem_wdata  output  64  lane-shifted store data
- dmem_gnt  input  1  request accepted
- dmem_rvalid  input  1  load data valid
- dmem_rdata  input  64  load data
- valid_mem  output  1  result valid this cycle
- op_mem  output  64  result/load data
- rd_mem  output  5  destination register
- we_rd_mem  output  1  register write enable
- reg_type_mem  output  1  register-file type
- misalign_mem  output  1  misaligned-access exception flag

Behaviour:
- Reset: all outputs 0, FSM to IDLE, pipeline register cleared. Reset mid-transaction drops dmem_req immediately; a later dmem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE, accepting: with valid_ex=1 and stall_mem=0, capture all *_ex inputs on the clock edge.
  - MEM_NONE: next cycle valid_mem=1, op_mem=op_ex, controls passed through. Latency 1.
  - Aligned load/store: go to REQ.
  - Misaligned (half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0): no request issued; next cycle valid_mem=1, misalign_mem=1, we_rd_mem=0.
- REQ: dmem_req=1, with addr, be and wdata held stable until dmem_gnt.
  - Store with gnt: back to IDLE; next cycle valid_mem=1, we_rd_mem=0.
  - Load with gnt: go to WAIT.
- WAIT: on dmem_rvalid, capture the aligned/extended data.
  - Next cycle valid_mem=1, op_mem=load result, we_rd_mem=captured we_rd.
  - Return to IDLE.
  - rvalid in the same cycle as gnt is illegal (single outstanding; data at least 1 cycle after gnt).
- stall_mem = (state != IDLE) OR (state==IDLE AND an aligned mem op is being accepted this cycle is not stalling) — i.e. stall_mem=1 exactly while in REQ or WAIT. The execute stage holds its outputs while stall_mem=1.
- valid_mem is a single-cycle pulse per instruction. Outside the pulse, op_mem/rd_mem hold their last values and we_rd_mem=0.
- Byte enables and store data:
  - dmem_be: SB=1<<a, SH=3<<a, SW=0xF<<a, SD=0xFF, where a=addr[2:0].
  - dmem_wdata = op_ex << (8*a).
- Load extraction: shift dmem_rdata right by 8*a, then size-extend.
  - LB/LH/LW: sign-extend. LBU/LHU/LWU: zero-extend. LD: unchanged.
  - FP word load (LW with reg_type=1): NaN-box, upper 32 bits = 0xFFFFFFFF.
- Back-to-back: one instruction is accepted in the same cycle valid_mem pulses for the previous one when in IDLE; this gives full throughput for non-mem ops.

Decomposition:
- riscv_pkg:
  - mem_op_e (MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD; 4 bits)
  - mem_state_e
  - helper function is_store
  - ADDR_W/XLEN constants
- Sub-module load_align: combinational extract, sign/zero-extend and NaN-box from (rdata, addr[2:0], mem_op, reg_type).

Test Plan:
- MEM_NONE, op_ex=0x1234, rd=5, we=1 -> next cycle valid_mem=1, op_mem=0x1234, rd_mem=5, we_rd_mem=1, stall_mem never asserted.
- SB, addr=0x1003, op_ex=0xAB, gnt after 2 cycles -> dmem_be=0x08, dmem_wdata[31:24]=0xAB, dmem_req held 3 cycles, valid_mem with we_rd_mem=0.
- LB, addr=0x2006, rdata=0x0080_0000_0000_0000 -> op_mem=0xFFFF_FFFF_FFFF_FF80; same access with LBU -> 0x80.
- FP LW, reg_type=1, addr=0x10, rdata low word=0x3F800000 -> op_mem=0xFFFF_FFFF_3F80_0000, reg_type_mem=1.
- LD, addr=0x...4 -> no dmem_req, misalign_mem=1, we_rd_mem=0, 1-cycle latency.
- n_reset low while in WAIT, then rvalid after reset release -> dmem_req=0 immediately, all outputs 0, late rvalid causes no valid_mem.
